vscale_fetch_queue: RTL and testbench



---
 rtl/vscale_fetch_queue_pkg.sv | 17 +
 rtl/vscale_fetch_queue_if.sv | 31 +++
 rtl/vscale_fetch_fifo.sv | 54 +++++
 rtl/vscale_fetch_queue.sv | 108 ++++++++++
 tb/tb_vscale_fetch_queue.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vscale_fetch_queue_pkg.sv
// Shared constants for the decoupled fetch unit: FSM encodings, widths and the NOP filler.
// Build option VSCALE_FETCH_BYPASS_EN (see vscale_fetch_queue.sv) does not change anything here.
package vscale_fetch_queue_pkg;

    localparam int XPR_LEN = 32;
    localparam logic [XPR_LEN-1:0] RV_NOP = 32'h0000_0013;

    localparam int FETCH_STATE_WIDTH = 1;
    localparam logic [FETCH_STATE_WIDTH-1:0] FETCH  = 1'b0;
    localparam logic [FETCH_STATE_WIDTH-1:0] HALTED = 1'b1;

    // A queue entry is {instruction, pc, badmem}.
    function automatic int entry_width(input int xlen);
        return 2 * xlen + 1;
    endfunction

endpackage

// File: rtl/vscale_fetch_queue_if.sv
// Bundles the redirect, instruction-memory and DX-side handshakes of the fetch unit.
// master = fetch unit, slave = memory/pipeline environment.
interface vscale_fetch_queue_if
    import vscale_fetch_queue_pkg::*;
#(
    parameter int XLEN = XPR_LEN
);
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req_valid;
    logic [XLEN-1:0] imem_addr;
    logic            imem_wait;
    logic [XLEN-1:0] imem_rdata;
    logic            imem_badmem_e;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;
    logic            inst_badmem;

    modport master (
        input  redirect_valid, redirect_pc, imem_wait, imem_rdata, imem_badmem_e, inst_ready,
        output imem_req_valid, imem_addr, inst_valid, inst, inst_pc, inst_badmem
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_wait, imem_rdata, imem_badmem_e, inst_ready,
        input  imem_req_valid, imem_addr, inst_valid, inst, inst_pc, inst_badmem
    );

endinterface

// File: rtl/vscale_fetch_fifo.sv
// Generic synchronous FIFO with same-cycle flush; DEPTH must be a power of two so the
// pointers wrap naturally.
module vscale_fetch_fifo
    import vscale_fetch_queue_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   enq,
    input  logic [WIDTH-1:0]       din,
    input  logic                   deq,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    always_ff @(posedge clk) begin
        if (enq && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/vscale_fetch_queue.sv
// Decoupled instruction fetch: owns the fetch PC, keeps up to DEPTH requests/instructions,
// flushes on redirect and halts after a bus fault. Define VSCALE_FETCH_BYPASS_EN for the empty-queue bypass.
module vscale_fetch_queue
    import vscale_fetch_queue_pkg::*;
#(
    parameter int              XLEN     = XPR_LEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'hf000_0100
) (
    input  logic                 clk,
    input  logic                 reset,
    vscale_fetch_queue_if.master bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int EW    = entry_width(XLEN);

    logic [FETCH_STATE_WIDTH-1:0] state;
    logic [XLEN-1:0]  fetch_pc;
    logic [XLEN-1:0]  req_pc_q;
    logic [XLEN-1:0]  req_addr;
    logic             inflight_q;
    logic             req_valid;
    logic             accept;
    logic             take;
    logic             bypass;
    logic             enq;
    logic             deq;
    logic             fifo_empty;
    logic             head_valid;
    logic             out_valid;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] occupancy;
    logic [EW-1:0]    resp_entry;
    logic [EW-1:0]    head;
    logic [EW-1:0]    out_entry;

    // Dequeues are deliberately not credited, keeping inst_ready off the imem request path.
    assign occupancy = count + CNT_W'(inflight_q);
    assign req_valid = ~reset & (((state == FETCH) & (occupancy < CNT_W'(DEPTH))) | bus.redirect_valid);
    assign req_addr  = bus.redirect_valid ? bus.redirect_pc : fetch_pc;
    assign accept    = req_valid & ~bus.imem_wait;

    assign take       = inflight_q & ~bus.redirect_valid;
    assign resp_entry = {bus.imem_rdata, req_pc_q, bus.imem_badmem_e};
    assign head_valid = ~fifo_empty;

    always_comb begin
        bypass = 1'b0;
`ifdef VSCALE_FETCH_BYPASS_EN
        bypass = take & fifo_empty;
`endif
    end

    assign enq       = take & ~(bypass & bus.inst_ready);
    assign deq       = head_valid & bus.inst_ready & ~bus.redirect_valid;
    assign out_entry = bypass ? resp_entry : head;
    assign out_valid = head_valid | bypass;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else if (bus.redirect_valid) begin
            state <= FETCH;
        end else if (take && bus.imem_badmem_e) begin
            state <= HALTED;
        end
    end

    // An unaccepted redirect still retargets fetch so the next attempt uses redirect_pc.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc   <= RESET_PC;
            inflight_q <= 1'b0;
            req_pc_q   <= '0;
        end else begin
            inflight_q <= accept;
            if (accept) begin
                fetch_pc <= req_addr + XLEN'(4);
                req_pc_q <= req_addr;
            end else if (bus.redirect_valid) begin
                fetch_pc <= bus.redirect_pc;
            end
        end
    end

    vscale_fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) fifo (
        .clk   (clk),
        .reset (reset),
        .flush (bus.redirect_valid),
        .enq   (enq),
        .din   (resp_entry),
        .deq   (deq),
        .dout  (head),
        .count (count),
        .empty (fifo_empty)
    );

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_addr      = req_addr;
    assign bus.inst_valid     = out_valid;
    assign bus.inst           = out_valid ? out_entry[EW-1 -: XLEN] : XLEN'(RV_NOP);
    assign bus.inst_pc        = out_valid ? out_entry[XLEN:1] : '0;
    assign bus.inst_badmem    = out_valid & out_entry[0];

endmodule

// File: tb/tb_vscale_fetch_queue.sv
// Scoreboard bench for vscale_fetch_queue: a stream-level fetch model predicts requests and
// delivered instructions; a separate monitor checks every consumed instruction.
module tb_vscale_fetch_queue;
    import vscale_fetch_queue_pkg::*;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'hf000_0100;
`ifdef VSCALE_FETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic        bad;
    } entry_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vscale_fetch_queue_if #(.XLEN(XLEN)) bus();

    vscale_fetch_queue #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    entry_t      sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          accepted = 0;
    int          consumed = 0;
    int          consumed_bad = 0;
    int          first_consume_cyc = -1;
    logic [31:0] first_consume_pc = '0;

    // Stream model: next sequential fetch address, outstanding request, fault halt.
    logic [31:0] stream_pc = RESET_PC;
    bit          halted = 0;
    bit          pend_valid = 0;
    logic [31:0] pend_addr = '0;
    int          fault_mode = 0;
    logic [31:0] fault_addr = '0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'h5a5a_0f0f;
    endfunction

    function automatic bit is_fault(input logic [31:0] a);
        if (fault_mode == 1) return (a == fault_addr);
        if (fault_mode == 2) return (a[7:2] == 6'h15);
        return 1'b0;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit rdr, input logic [31:0] rpc,
                                 input bit rdy, input bit wt);
        logic [31:0] exp_addr;
        bit resp_taken;
        bit resp_fault;
        bit acc;
        @(posedge clk);
        #1;
        cyc++;
        reset              = rst;
        bus.redirect_valid = rdr;
        bus.redirect_pc    = rpc;
        bus.inst_ready     = rdy;
        bus.imem_wait      = wt;
        if (pend_valid) begin
            bus.imem_rdata    = mem_data(pend_addr);
            bus.imem_badmem_e = is_fault(pend_addr);
        end else begin
            bus.imem_rdata    = $urandom;
            bus.imem_badmem_e = 1'($urandom_range(0, 1));
        end
        #3;
        if (rst) begin
            checkOutput("req_in_reset", 32'(bus.imem_req_valid), 32'd0);
            sb.delete();
            stream_pc  = RESET_PC;
            halted     = 0;
            pend_valid = 0;
        end else begin
            resp_taken = pend_valid && !rdr;
            resp_fault = resp_taken && is_fault(pend_addr);
            if (rdr) sb.delete();
            if (resp_taken) begin
                sb.push_back('{pc: pend_addr, data: mem_data(pend_addr), bad: resp_fault});
                checkOutput("occupancy_bound", 32'(sb.size() <= DEPTH), 32'd1);
            end
            if (halted && !rdr) checkOutput("no_req_halted", 32'(bus.imem_req_valid), 32'd0);
            exp_addr = rdr ? rpc : stream_pc;
            if (bus.imem_req_valid) checkOutput("req_addr", bus.imem_addr, exp_addr);
            acc = bus.imem_req_valid && !wt;
            if (rdr) halted = 0;
            if (resp_fault) halted = 1;
            if (acc) begin
                accepted++;
                stream_pc = exp_addr + 32'd4;
                pend_addr = exp_addr;
            end else if (rdr) begin
                stream_pc = rpc;
            end
            pend_valid = acc;
        end
    endtask

    task automatic run(input int n, input bit rdy);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, rdy, 0);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic arm_first();
        settle();
        first_consume_cyc = -1;
    endtask

    always @(negedge clk) begin : monitor
        entry_t e;
        if (reset === 1'b0) begin
            if (!bus.redirect_valid && bus.inst_valid && bus.inst_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_inst: got pc %h, expected no instruction (cycle %0d)",
                             bus.inst_pc, cyc);
                end else begin
                    e = sb.pop_front();
                    checkOutput("inst_pc", bus.inst_pc, e.pc);
                    checkOutput("inst", bus.inst, e.data);
                    checkOutput("inst_badmem", 32'(bus.inst_badmem), 32'(e.bad));
                end
                consumed++;
                if (bus.inst_badmem) consumed_bad++;
                if (first_consume_cyc < 0) begin
                    first_consume_cyc = cyc;
                    first_consume_pc  = bus.inst_pc;
                end
            end else if (!bus.inst_valid) begin
                checkOutput("nop_when_idle", bus.inst, RV_NOP);
                checkOutput("pc_when_idle", bus.inst_pc, 32'd0);
            end
        end
    end

    initial begin
        int base;
        int c0;
        int b0;
        bit rst;
        bit rdr;
        reset              = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.inst_ready     = 1'b0;
        bus.imem_wait      = 1'b0;
        bus.imem_rdata     = '0;
        bus.imem_badmem_e  = 1'b0;

        $display("[TB] reset and straight-line fetch");
        applyStimulus(1, 0, '0, 1, 0);
        applyStimulus(1, 0, '0, 1, 0);
        first_consume_cyc = -1;
        base = cyc;
        c0 = consumed;
        applyStimulus(0, 0, '0, 1, 0);
        checkOutput("first_req_valid", 32'(bus.imem_req_valid), 32'd1);
        checkOutput("first_req_addr", bus.imem_addr, RESET_PC);
        run(11, 1);
        settle();
        checkOutput("first_latency", 32'(first_consume_cyc - (base + 1)), 32'(LAT));
        checkOutput("first_pc", first_consume_pc, RESET_PC);
        checkOutput("stream_throughput", 32'(consumed - c0), 32'(12 - LAT));

        $display("[TB] stall fills queue");
        accepted = 0;
        applyStimulus(0, 1, 32'h0000_0400, 0, 0);
        run(10, 0);
        checkOutput("stall_requests", 32'(accepted), 32'(DEPTH));
        checkOutput("stall_req_low", 32'(bus.imem_req_valid), 32'd0);
        settle();
        c0 = consumed;
        run(10, 1);
        settle();
        checkOutput("release_throughput", 32'(consumed - c0), 32'd10);

        $display("[TB] imem_wait holds request");
        applyStimulus(0, 1, 32'h0000_0100, 1, 0);
        applyStimulus(0, 0, '0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, '0, 1, 1);
            checkOutput("wait_req_valid", 32'(bus.imem_req_valid), 32'd1);
            checkOutput("wait_hold_addr", bus.imem_addr, 32'h0000_0108);
        end
        run(8, 1);

        $display("[TB] redirect flushes queue and in-flight response");
        applyStimulus(0, 1, 32'h0000_0300, 0, 0);
        run(4, 0);
        arm_first();
        applyStimulus(0, 1, 32'h0000_0200, 1, 0);
        base = cyc;
        run(6, 1);
        settle();
        checkOutput("redirect_first_pc", first_consume_pc, 32'h0000_0200);
        checkOutput("redirect_latency", 32'(first_consume_cyc - base), 32'(LAT));

        $display("[TB] bus fault halts fetch");
        fault_mode = 1;
        fault_addr = 32'h0000_020c;
        b0 = consumed_bad;
        applyStimulus(0, 1, 32'h0000_0200, 1, 0);
        run(15, 1);
        settle();
        checkOutput("fault_delivered", 32'(consumed_bad - b0), 32'd1);
        checkOutput("halted_req_low", 32'(bus.imem_req_valid), 32'd0);
        fault_mode = 0;
        arm_first();
        applyStimulus(0, 1, 32'h0000_0100, 1, 0);
        run(8, 1);
        settle();
        checkOutput("resume_pc", first_consume_pc, 32'h0000_0100);

        $display("[TB] reset mid-stream");
        arm_first();
        applyStimulus(1, 0, '0, 1, 0);
        base = cyc;
        run(8, 1);
        settle();
        checkOutput("reset_restart_pc", first_consume_pc, RESET_PC);
        checkOutput("reset_restart_latency", 32'(first_consume_cyc - (base + 1)), 32'(LAT));

        $display("[TB] randomized traffic");
        fault_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            rdr = !rst && (($urandom_range(0, 29) == 0) || (halted && $urandom_range(0, 7) == 0));
            applyStimulus(rst, rdr, 32'($urandom) & 32'hffff_fffc,
                          $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
        end

        $display("[TB] final fault and drain");
        fault_mode = 1;
        fault_addr = 32'h0000_050c;
        b0 = consumed_bad;
        applyStimulus(0, 1, 32'h0000_0500, 1, 0);
        run(30, 1);
        settle();
        checkOutput("drain_empty", 32'(sb.size()), 32'd0);
        checkOutput("drain_fault_delivered", 32'(consumed_bad - b0), 32'd1);
        checkOutput("drain_req_low", 32'(bus.imem_req_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
